// File: rtl/ama_riscv_csr_arb.sv
// CSR port arbiter: the core EXE stage owns the CSR bus by default; host/debug
// requests are latched, issued in an idle CSR cycle, or forced after MAX_WAIT losses.

package ama_riscv_csr_pkg;

    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    typedef struct packed {
        logic       en;
        logic       ui;
        logic [1:0] op;
        logic       we;
        logic       re;
    } csr_ctrl_t;

endpackage

module ama_riscv_csr_arb
    import ama_riscv_csr_pkg::*;
#(
    parameter int ARCH_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  csr_ctrl_t             core_ctrl,
    input  logic [ARCH_WIDTH-1:0] core_in,
    input  logic [ARCH_WIDTH-1:0] core_inst,
    output logic [ARCH_WIDTH-1:0] core_out,
    output logic                  core_stall,
    input  logic                  host_req,
    input  logic [11:0]           host_addr,
    input  logic [1:0]            host_op,
    input  logic                  host_we,
    input  logic                  host_re,
    input  logic [ARCH_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [ARCH_WIDTH-1:0] host_rdata,
    output csr_ctrl_t             csr_ctrl,
    output logic [ARCH_WIDTH-1:0] csr_in,
    output logic [ARCH_WIDTH-1:0] csr_inst,
    input  logic [ARCH_WIDTH-1:0] csr_out
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RESP
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            wait_cnt;
    logic [7:0]            wait_cnt_nxt;
    logic                  host_issue;

    logic [11:0]           lat_addr;
    logic [1:0]            lat_op;
    logic                  lat_we;
    logic                  lat_re;
    logic [ARCH_WIDTH-1:0] lat_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        host_issue   = 1'b0;
        core_stall   = 1'b0;
        case (state)
            IDLE: begin
                if (host_req) state_nxt = PEND;
            end
            PEND: begin
                if (!core_ctrl.en) begin
                    host_issue   = 1'b1;
                    state_nxt    = RESP;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt < MAX_W) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end else begin
                    // Starvation bound hit: the core loses this one cycle and reissues
                    core_stall   = 1'b1;
                    host_issue   = 1'b1;
                    state_nxt    = RESP;
                    wait_cnt_nxt = '0;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        csr_ctrl = core_ctrl;
        csr_in   = core_in;
        csr_inst = core_inst;
        core_out = csr_out;
        if (host_issue) begin
            csr_ctrl.en = 1'b1;
            csr_ctrl.ui = 1'b0;
            csr_ctrl.op = lat_op;
            csr_ctrl.we = lat_we;
            // Set/clear need the old value, so they always imply a read
            csr_ctrl.re = lat_re | (lat_op == CSR_OP_RS) | (lat_op == CSR_OP_RC);
            csr_in      = lat_wdata;
            csr_inst    = {lat_addr, {(ARCH_WIDTH-12){1'b0}}};
            core_out    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr   <= '0;
            lat_op     <= '0;
            lat_we     <= 1'b0;
            lat_re     <= 1'b0;
            lat_wdata  <= '0;
            host_rdata <= '0;
        end else begin
            if (state == IDLE && host_req) begin
                lat_addr  <= host_addr;
                lat_op    <= host_op;
                lat_we    <= host_we;
                lat_re    <= host_re;
                lat_wdata <= host_wdata;
            end
            if (host_issue) begin
                host_rdata <= (lat_we | lat_re) ? csr_out : '0;
            end
        end
    end

    assign host_ack = (state == RESP);

endmodule

// File: tb/tb_ama_riscv_csr_arb.sv
// Directed bench for ama_riscv_csr_arb with a small behavioural CSR file
// (mscratch, tohost) answering on the arbitrated bus.

module tb_ama_riscv_csr_arb;
    import ama_riscv_csr_pkg::*;

    localparam logic [11:0] MSCRATCH = 12'h340;
    localparam logic [11:0] TOHOST   = 12'h780;

    logic        clk = 1'b0;
    logic        rst;
    csr_ctrl_t   core_ctrl;
    logic [31:0] core_in;
    logic [31:0] core_inst;
    logic [31:0] core_out;
    logic        core_stall;
    logic        host_req;
    logic [11:0] host_addr;
    logic [1:0]  host_op;
    logic        host_we;
    logic        host_re;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    csr_ctrl_t   csr_ctrl;
    logic [31:0] csr_in;
    logic [31:0] csr_inst;
    logic [31:0] csr_out;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mscratch_m = 32'h0;
    logic [31:0] tohost_m   = 32'h0;
    logic [31:0] opnd_m;
    logic [31:0] new_m;

    always #5 clk = ~clk;

    ama_riscv_csr_arb #(.ARCH_WIDTH(32), .MAX_WAIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_ctrl  (core_ctrl),
        .core_in    (core_in),
        .core_inst  (core_inst),
        .core_out   (core_out),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_op    (host_op),
        .host_we    (host_we),
        .host_re    (host_re),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .csr_ctrl   (csr_ctrl),
        .csr_in     (csr_in),
        .csr_inst   (csr_inst),
        .csr_out    (csr_out)
    );

    assign csr_out = (csr_inst[31:20] == MSCRATCH) ? mscratch_m :
                     (csr_inst[31:20] == TOHOST)   ? tohost_m   : 32'h0;

    // Reference CSR file: combinational read, write/set/clear on the clock edge
    always @(posedge clk) begin
        if (csr_ctrl.en && csr_ctrl.we) begin
            opnd_m = csr_ctrl.ui ? {27'h0, csr_inst[19:15]} : csr_in;
            case (csr_ctrl.op)
                CSR_OP_RW: new_m = opnd_m;
                CSR_OP_RS: new_m = csr_out | opnd_m;
                CSR_OP_RC: new_m = csr_out & ~opnd_m;
                default:   new_m = csr_out;
            endcase
            if (csr_inst[31:20] == MSCRATCH) mscratch_m <= new_m;
            else if (csr_inst[31:20] == TOHOST) tohost_m <= new_m;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic set_core(input logic en, input logic we, input logic re, input logic [1:0] op,
                            input logic [11:0] addr, input logic [31:0] data);
        core_ctrl.en = en;
        core_ctrl.ui = 1'b0;
        core_ctrl.op = op;
        core_ctrl.we = we;
        core_ctrl.re = re;
        core_inst    = {addr, 20'h0};
        core_in      = data;
    endtask

    task automatic core_idle();
        set_core(1'b0, 1'b0, 1'b0, CSR_OP_RW, 12'h0, 32'h0);
    endtask

    task automatic set_host(input logic req, input logic [11:0] addr, input logic [1:0] op,
                            input logic we, input logic re, input logic [31:0] wdata);
        host_req   = req;
        host_addr  = addr;
        host_op    = op;
        host_we    = we;
        host_re    = re;
        host_wdata = wdata;
    endtask

    initial begin
        logic [5:0] b2b_ack;
        b2b_ack = 6'b100100;

        rst = 1'b0;
        core_idle();
        set_host(1'b0, 12'h0, CSR_OP_RW, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_ack",   32'(host_ack),    32'h0);
        check_output("rst_rdata", host_rdata,       32'h0);
        check_output("rst_stall", 32'(core_stall),  32'h0);
        check_output("rst_bus",   32'(csr_ctrl.en), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Core preloads mscratch
        set_core(1'b1, 1'b1, 1'b0, CSR_OP_RW, MSCRATCH, 32'h1234);
        #1;
        check_output("pre_stall", 32'(core_stall), 32'h0);
        check_output("pre_in",    csr_in,           32'h1234);

        // Uncontended read
        @(negedge clk);
        core_idle();
        set_host(1'b1, MSCRATCH, CSR_OP_RW, 1'b0, 1'b1, 32'h0);
        #1;
        check_output("t1_latch_en", 32'(csr_ctrl.en), 32'h0);
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check_output("t1_issue_en",   32'(csr_ctrl.en),      32'h1);
        check_output("t1_issue_addr", 32'(csr_inst[31:20]),  32'h340);
        check_output("t1_issue_stall",32'(core_stall),       32'h0);
        check_output("t1_early_ack",  32'(host_ack),         32'h0);
        @(negedge clk);
        #1;
        check_output("t1_ack",   32'(host_ack), 32'h1);
        check_output("t1_rdata", host_rdata,    32'h1234);
        @(negedge clk);
        #1;
        check_output("t1_ack_once",  32'(host_ack), 32'h0);
        check_output("t1_rdata_hold",host_rdata,    32'h1234);

        // Contended write: core busy for three cycles after the latch
        set_host(1'b1, TOHOST, CSR_OP_RW, 1'b1, 1'b0, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host_req = 1'b0;
            set_core(1'b1, 1'b1, 1'b0, CSR_OP_RW, MSCRATCH, 32'h11 * (i + 1));
            #1;
            check_output("t2_core_stall", 32'(core_stall), 32'h0);
            check_output("t2_core_in",    csr_in,           32'h11 * (i + 1));
        end
        @(negedge clk);
        core_idle();
        #1;
        check_output("t2_issue_in", csr_in,           32'hA5);
        check_output("t2_issue_we", 32'(csr_ctrl.we), 32'h1);
        @(negedge clk);
        #1;
        check_output("t2_ack",      32'(host_ack), 32'h1);
        check_output("t2_tohost",   tohost_m,      32'hA5);
        check_output("t2_mscratch", mscratch_m,    32'h33);
        check_output("t2_rdata",    host_rdata,    32'h0);

        // Starvation: core busy continuously, host forced through after 8 losses
        @(negedge clk);
        set_host(1'b1, MSCRATCH, CSR_OP_RW, 1'b0, 1'b1, 32'h0);
        set_core(1'b1, 1'b0, 1'b1, CSR_OP_RW, TOHOST, 32'h0);
        #1;
        check_output("t3_latch_stall", 32'(core_stall), 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            host_req = 1'b0;
            #1;
            check_output("t3_core_stall", 32'(core_stall), 32'h0);
            check_output("t3_core_out",   core_out,         32'hA5);
        end
        @(negedge clk);
        set_core(1'b1, 1'b1, 1'b0, CSR_OP_RW, MSCRATCH, 32'h99);
        #1;
        check_output("t3_forced_stall", 32'(core_stall),      32'h1);
        check_output("t3_forced_we",    32'(csr_ctrl.we),     32'h0);
        check_output("t3_forced_addr",  32'(csr_inst[31:20]), 32'h340);
        check_output("t3_forced_out",   core_out,             32'h0);
        @(negedge clk);
        #1;
        check_output("t3_ack",        32'(host_ack),   32'h1);
        check_output("t3_reissue",    32'(core_stall), 32'h0);
        check_output("t3_rdata",      host_rdata,      32'h33);
        check_output("t3_no_side_eff",mscratch_m,      32'h33);
        @(negedge clk);
        core_idle();
        #1;
        check_output("t3_reissue_done", mscratch_m, 32'h99);

        // Set-bits read-modify-write
        @(negedge clk);
        set_core(1'b1, 1'b1, 1'b0, CSR_OP_RW, MSCRATCH, 32'hF0);
        @(negedge clk);
        core_idle();
        set_host(1'b1, MSCRATCH, CSR_OP_RS, 1'b1, 1'b0, 32'h0F);
        #1;
        check_output("t4_pre", mscratch_m, 32'hF0);
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check_output("t4_re", 32'(csr_ctrl.re), 32'h1);
        check_output("t4_op", 32'(csr_ctrl.op), 32'(CSR_OP_RS));
        check_output("t4_in", csr_in,            32'h0F);
        @(negedge clk);
        #1;
        check_output("t4_ack",   32'(host_ack), 32'h1);
        check_output("t4_rdata", host_rdata,    32'hF0);
        @(negedge clk);
        #1;
        check_output("t4_result", mscratch_m, 32'hFF);

        // Reset while a host request is pending behind a busy core
        set_host(1'b1, TOHOST, CSR_OP_RW, 1'b0, 1'b1, 32'h0);
        set_core(1'b1, 1'b0, 1'b1, CSR_OP_RW, MSCRATCH, 32'h0);
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check_output("t5_pend_stall", 32'(core_stall), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_output("t5_rst_ack",   32'(host_ack),   32'h0);
        check_output("t5_rst_rdata", host_rdata,      32'h0);
        check_output("t5_rst_stall", 32'(core_stall), 32'h0);
        @(negedge clk);
        core_idle();
        #1;
        check_output("t5_rst_ack2", 32'(host_ack), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("t5_post_ack", 32'(host_ack),    32'h0);
        check_output("t5_post_bus", 32'(csr_ctrl.en), 32'h0);
        @(negedge clk);
        set_host(1'b1, MSCRATCH, CSR_OP_RW, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check_output("t5_new_issue", 32'(csr_ctrl.en), 32'h1);
        check_output("t5_new_early", 32'(host_ack),    32'h0);
        @(negedge clk);
        #1;
        check_output("t5_new_ack",   32'(host_ack), 32'h1);
        check_output("t5_new_rdata", host_rdata,    32'hFF);

        // Back-to-back requests with host_req held high
        @(negedge clk);
        set_host(1'b1, TOHOST, CSR_OP_RW, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check_output("t6_ack", 32'(host_ack), 32'(b2b_ack[i]));
            if (b2b_ack[i]) check_output("t6_rdata", host_rdata, 32'hA5);
            @(negedge clk);
        end
        host_req = 1'b0;

        // Request with neither read nor write intent
        @(negedge clk);
        set_host(1'b1, MSCRATCH, CSR_OP_RW, 1'b0, 1'b0, 32'h55);
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check_output("t7_issue_en", 32'(csr_ctrl.en), 32'h1);
        check_output("t7_issue_we", 32'(csr_ctrl.we), 32'h0);
        @(negedge clk);
        #1;
        check_output("t7_ack",      32'(host_ack), 32'h1);
        check_output("t7_rdata",    host_rdata,    32'h0);
        check_output("t7_mscratch", mscratch_m,    32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
